// File: rtl/svreal_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : svreal_alu_pipe
// Purpose  : Pipelined fixed-point ALU over svreal-format operands. It
//            supports ADD/SUB/MUL/MIN/MAX/NEG/MAC, uses a valid/ready
//            handshake, and has PIPE_DEPTH register stages from input to
//            output. The whole pipe advances as one unit.
// Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//            in_valid/in_ready   - operand beat handshake
//            op, acc_clr         - operation select, accumulator clear
//            a_val, b_val        - signed operand mantissas
//            out_valid/out_ready - result beat handshake
//            out_val             - signed result mantissa at O_EXPONENT
//            out_cmp             - {ge, gt, le, lt} of exact a versus b
//            out_sat             - result was clipped (sat build only)
// Options  : define SVREAL_SAT_EN to clamp on narrowing instead of wrapping
// Revision : 1.0 - initial release
// ============================================================================
module svreal_alu_pipe #(
  parameter int A_WIDTH    = 16,
  parameter int A_EXPONENT = -8,
  parameter int B_WIDTH    = 17,
  parameter int B_EXPONENT = -9,
  parameter int O_WIDTH    = 18,
  parameter int O_EXPONENT = -10,
  parameter int PIPE_DEPTH = 2     // legal range 1..8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                op,
  input  logic                      acc_clr,
  input  logic signed [A_WIDTH-1:0] a_val,
  input  logic signed [B_WIDTH-1:0] b_val,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [O_WIDTH-1:0] out_val,
  output logic [3:0]                out_cmp,
  output logic                      out_sat
);

  localparam logic [2:0] C_OP_ADD = 3'd0;
  localparam logic [2:0] C_OP_SUB = 3'd1;
  localparam logic [2:0] C_OP_MUL = 3'd2;
  localparam logic [2:0] C_OP_MIN = 3'd3;
  localparam logic [2:0] C_OP_MAX = 3'd4;
  localparam logic [2:0] C_OP_NEG = 3'd5;
  localparam logic [2:0] C_OP_MAC = 3'd6;

  // Shift from each source exponent to the result exponent (positive = left).
  localparam int SA = A_EXPONENT - O_EXPONENT;
  localparam int SB = B_EXPONENT - O_EXPONENT;
  localparam int SP = A_EXPONENT + B_EXPONENT - O_EXPONENT;
  localparam int PW = A_WIDTH + B_WIDTH;

  // Internal width: the widest aligned term plus headroom for one add/sub/negate.
  localparam int LA = A_WIDTH + ((SA > 0) ? SA : 0);
  localparam int LB = B_WIDTH + ((SB > 0) ? SB : 0);
  localparam int LP = PW + ((SP > 0) ? SP : 0);
  localparam int L1 = (LA > LB) ? LA : LB;
  localparam int L2 = (LP > O_WIDTH) ? LP : O_WIDTH;
  localparam int IW = ((L1 > L2) ? L1 : L2) + 2;

  // Exact comparison aligns both operands losslessly to the finer exponent.
  localparam int CE  = (A_EXPONENT < B_EXPONENT) ? A_EXPONENT : B_EXPONENT;
  localparam int CA  = A_EXPONENT - CE;
  localparam int CB  = B_EXPONENT - CE;
  localparam int CWA = A_WIDTH + CA;
  localparam int CWB = B_WIDTH + CB;
  localparam int CW  = ((CWA > CWB) ? CWA : CWB) + 1;

  logic                      advance;
  logic                      accept;

  logic signed [PW-1:0]      prod;
  logic signed [IW-1:0]      a_ext;
  logic signed [IW-1:0]      b_ext;
  logic signed [IW-1:0]      p_ext;
  logic signed [IW-1:0]      a_al;
  logic signed [IW-1:0]      b_al;
  logic signed [IW-1:0]      p_al;
  logic signed [IW-1:0]      acc_base;
  logic signed [IW-1:0]      mac_sum;
  logic signed [IW-1:0]      res_wide;

  logic signed [CW-1:0]      a_cmp;
  logic signed [CW-1:0]      b_cmp;
  logic                      cmp_lt;
  logic                      cmp_le;
  logic                      cmp_gt;
  logic                      cmp_ge;

  logic signed [O_WIDTH-1:0] res_val;
  logic                      res_sat;

  logic signed [O_WIDTH-1:0] acc_q;
  logic signed [O_WIDTH-1:0] acc_d;

  logic                      vld_q [PIPE_DEPTH];
  logic signed [O_WIDTH-1:0] val_q [PIPE_DEPTH];
  logic [3:0]                cmp_q [PIPE_DEPTH];
  logic                      sat_q [PIPE_DEPTH];

  // --------------------------------------------------------------------------
  // Handshake: the pipe moves only when the output slot is free or drained.
  // --------------------------------------------------------------------------
  assign advance  = !vld_q[PIPE_DEPTH-1] || out_ready;
  assign in_ready = rst_n && advance;
  assign accept   = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Operand alignment to O_EXPONENT. Right shifts are arithmetic, so
  // truncation rounds toward negative infinity.
  // --------------------------------------------------------------------------
  assign prod  = PW'(a_val) * PW'(b_val);
  assign a_ext = IW'(a_val);
  assign b_ext = IW'(b_val);
  assign p_ext = IW'(prod);

  if (SA >= 0) begin : g_a_left
    assign a_al = a_ext <<< SA;
  end else begin : g_a_right
    assign a_al = a_ext >>> (-SA);
  end

  if (SB >= 0) begin : g_b_left
    assign b_al = b_ext <<< SB;
  end else begin : g_b_right
    assign b_al = b_ext >>> (-SB);
  end

  if (SP >= 0) begin : g_p_left
    assign p_al = p_ext <<< SP;
  end else begin : g_p_right
    assign p_al = p_ext >>> (-SP);
  end

  assign a_cmp  = CW'(a_val) <<< CA;
  assign b_cmp  = CW'(b_val) <<< CB;
  assign cmp_lt = (a_cmp <  b_cmp);
  assign cmp_le = (a_cmp <= b_cmp);
  assign cmp_gt = (a_cmp >  b_cmp);
  assign cmp_ge = (a_cmp >= b_cmp);

  // --------------------------------------------------------------------------
  // Full-precision result. Only the final narrowing below can overflow.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_base = acc_clr ? '0 : IW'(acc_q);
    mac_sum  = acc_base + p_al;
    res_wide = '0;
    case (op)
      C_OP_ADD: res_wide = a_al + b_al;
      C_OP_SUB: res_wide = a_al - b_al;
      C_OP_MUL: res_wide = p_al;
      C_OP_MIN: res_wide = cmp_le ? a_al : b_al;   // ties return a
      C_OP_MAX: res_wide = cmp_ge ? a_al : b_al;   // ties return a
      C_OP_NEG: res_wide = -a_al;
      C_OP_MAC: res_wide = mac_sum;
      default:  res_wide = '0;
    endcase
  end

`ifdef SVREAL_SAT_EN
  // The value fits only if every bit from the sign down to bit O_WIDTH-1 matches.
  always_comb begin
    res_val = res_wide[O_WIDTH-1:0];
    res_sat = 1'b0;
    if (!res_wide[IW-1] && (|res_wide[IW-1:O_WIDTH-1])) begin
      res_val = {1'b0, {(O_WIDTH-1){1'b1}}};
      res_sat = 1'b1;
    end else if (res_wide[IW-1] && !(&res_wide[IW-1:O_WIDTH-1])) begin
      res_val = {1'b1, {(O_WIDTH-1){1'b0}}};
      res_sat = 1'b1;
    end
  end
`else
  logic unused_wrap_bits;

  // Two's-complement wrap: keep the low O_WIDTH bits and drop the rest.
  assign res_val          = res_wide[O_WIDTH-1:0];
  assign res_sat          = 1'b0;
  assign unused_wrap_bits = ^res_wide[IW-1:O_WIDTH];
`endif

  // --------------------------------------------------------------------------
  // Accumulator updates at acceptance, so back-to-back MACs see the new value.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      if (op == C_OP_MAC) begin
        acc_d = res_val;
      end else if (acc_clr) begin
        acc_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        vld_q[i] <= 1'b0;
        val_q[i] <= '0;
        cmp_q[i] <= '0;
        sat_q[i] <= 1'b0;
      end
    end else begin
      acc_q <= acc_d;
      if (advance) begin
        vld_q[0] <= in_valid;
        val_q[0] <= res_val;
        cmp_q[0] <= {cmp_ge, cmp_gt, cmp_le, cmp_lt};
        sat_q[0] <= res_sat;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          vld_q[i] <= vld_q[i-1];
          val_q[i] <= val_q[i-1];
          cmp_q[i] <= cmp_q[i-1];
          sat_q[i] <= sat_q[i-1];
        end
      end
    end
  end

  assign out_valid = vld_q[PIPE_DEPTH-1];
  assign out_val   = val_q[PIPE_DEPTH-1];
  assign out_cmp   = cmp_q[PIPE_DEPTH-1];
  assign out_sat   = sat_q[PIPE_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_svreal_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_svreal_alu_pipe
// Purpose  : Self-checking bench for svreal_alu_pipe with default operand
//            formats. Expected beats are pushed by a reference model on
//            acceptance and compared when the DUT delivers them. Extra
//            instances with PIPE_DEPTH 1 and 4 check latency.
// Options  : honours SVREAL_SAT_EN for the expected narrowing behaviour
// Revision : 1.0 - initial release
// ============================================================================
module tb_svreal_alu_pipe;

  typedef struct {
    logic signed [17:0] val;
    logic [3:0]         cmp;
    logic               sat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               in_valid;
  logic [2:0]         op;
  logic               acc_clr;
  logic signed [15:0] a_val;
  logic signed [16:0] b_val;
  logic               out_ready;

  logic               in_ready;
  logic               out_valid;
  logic signed [17:0] out_val;
  logic [3:0]         out_cmp;
  logic               out_sat;

  logic               d1_in_ready_unused;
  logic               d1_valid;
  logic signed [17:0] d1_val;
  logic [3:0]         d1_cmp_unused;
  logic               d1_sat_unused;

  logic               d4_in_ready_unused;
  logic               d4_valid;
  logic signed [17:0] d4_val;
  logic [3:0]         d4_cmp_unused;
  logic               d4_sat_unused;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  svreal_alu_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .acc_clr(acc_clr), .a_val(a_val), .b_val(b_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_val(out_val),
    .out_cmp(out_cmp), .out_sat(out_sat)
  );

  svreal_alu_pipe #(.PIPE_DEPTH(1)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d1_in_ready_unused),
    .op(op), .acc_clr(acc_clr), .a_val(a_val), .b_val(b_val),
    .out_valid(d1_valid), .out_ready(out_ready), .out_val(d1_val),
    .out_cmp(d1_cmp_unused), .out_sat(d1_sat_unused)
  );

  svreal_alu_pipe #(.PIPE_DEPTH(4)) dut_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d4_in_ready_unused),
    .op(op), .acc_clr(acc_clr), .a_val(a_val), .b_val(b_val),
    .out_valid(d4_valid), .out_ready(out_ready), .out_val(d4_val),
    .out_cmp(d4_cmp_unused), .out_sat(d4_sat_unused)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap18(input longint x);
    longint w;
    w = x & 64'h3FFFF;
    if (w >= 131072) w = w - 262144;
    return w;
  endfunction

  function automatic bit pat(input int j);
    return (j >= 0) && (j < 6) && (j % 2 == 0);
  endfunction

  // Reference model: rescale a (x4), b (x2), product (>>>7, floor) to 2^-10.
  longint m_acc = 0;
  longint m_a, m_b, m_aal, m_bal, m_pal, m_raw, m_res;
  logic   m_sat;
  exp_t   m_e;

  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      m_acc = 0;
    end else if (in_valid && in_ready) begin
      m_a   = longint'(a_val);
      m_b   = longint'(b_val);
      m_aal = m_a * 4;
      m_bal = m_b * 2;
      m_pal = (m_a * m_b) >>> 7;
      case (op)
        3'd0:    m_raw = m_aal + m_bal;
        3'd1:    m_raw = m_aal - m_bal;
        3'd2:    m_raw = m_pal;
        3'd3:    m_raw = (2 * m_a <= m_b) ? m_aal : m_bal;
        3'd4:    m_raw = (2 * m_a >= m_b) ? m_aal : m_bal;
        3'd5:    m_raw = -m_aal;
        3'd6:    m_raw = (acc_clr ? 64'sd0 : m_acc) + m_pal;
        default: m_raw = 0;
      endcase
`ifdef SVREAL_SAT_EN
      m_sat = (m_raw > 131071) || (m_raw < -131072);
      m_res = (m_raw > 131071) ? 131071 : ((m_raw < -131072) ? -131072 : m_raw);
`else
      m_sat = 1'b0;
      m_res = wrap18(m_raw);
`endif
      if (op == 3'd6) m_acc = m_res;
      else if (acc_clr) m_acc = 0;
      m_e.val = 18'(m_res);
      m_e.cmp = {2 * m_a >= m_b, 2 * m_a > m_b, 2 * m_a <= m_b, 2 * m_a < m_b};
      m_e.sat = m_sat;
      sb_q.push_back(m_e);
    end
  end

  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("out_val", out_val, mon_e.val);
        chk("out_cmp", out_cmp, mon_e.cmp);
        chk("out_sat", out_sat, mon_e.sat);
      end
    end
  end

  task automatic send(input logic [2:0] o, input int a, input int b, input logic clr);
    logic got;
    int   tries;
    op       = o;
    a_val    = 16'(a);
    b_val    = 17'(b);
    acc_clr  = clr;
    in_valid = 1'b1;
    tries    = 0;
    do begin
      #1;
      got = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!got && tries < 50);
    chk("send_accept", got, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int   sent;
  logic rdy;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; acc_clr = 1'b0;
    a_val = '0; b_val = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_cmp", out_cmp, 0);
    chk("rst_out_sat", out_sat, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Ops 0..5 back to back on 1.5 and 2.25
    for (int k = 0; k < 6; k++) send(3'(k), 384, 1152, 1'b0);
    idle(4);

    // Overflow on ADD, NEG of the most negative value, op 7, tie, floor
    send(3'd0, 25600, 51200, 1'b0);
    send(3'd5, -32768, 0, 1'b0);
    send(3'd7, 100, -300, 1'b0);
    send(3'd3, 100, 200, 1'b0);
    send(3'd2, -1, 1, 1'b0);
    idle(4);

    // MAC sequence, then acc_clr on a non-MAC beat
    send(3'd6, 256, 256, 1'b1);
    send(3'd6, 256, 256, 1'b0);
    send(3'd6, 256, 256, 1'b0);
    send(3'd6, 256, 256, 1'b1);
    send(3'd6, 256, 256, 1'b0);
    send(3'd0, 1, 2, 1'b1);
    send(3'd6, 256, 256, 1'b0);
    idle(4);

    // Backpressure: out_ready low on cycles 3-5
    sent = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid  = (sent < 6);
      op        = 3'd0;
      acc_clr   = 1'b0;
      a_val     = 16'(1000 + sent * 7);
      b_val     = 17'(-500 + sent * 13);
      #1;
      if (cyc < 8) chk("bp_in_ready", in_ready, (cyc >= 3 && cyc <= 5) ? 0 : 1);
      if (cyc >= 3 && cyc <= 5) begin
        chk("bp_hold_valid", out_valid, 1);
        if (sb_q.size() > 0) chk("bp_hold_val", out_val, sb_q[0].val);
      end
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy && in_valid) sent++;
    end
    out_ready = 1'b1;
    chk("bp_sent", sent, 6);
    idle(8);

    // Bubbles and latency across depths 1, 2 and 4
    for (int k = 0; k < 10; k++) begin
      in_valid = pat(k);
      op       = 3'd0;
      acc_clr  = 1'b0;
      a_val    = 16'(k * 3);
      b_val    = 17'(k);
      @(posedge clk); #1;
      chk("bub_valid_p2", out_valid, pat(k - 1));
      chk("bub_valid_p1", d1_valid, pat(k));
      chk("bub_valid_p4", d4_valid, pat(k - 3));
      if (pat(k)) chk("bub_val_p1", d1_val, 14 * k);
      if (pat(k - 3)) chk("bub_val_p4", d4_val, 14 * (k - 3));
    end
    idle(6);

    // Reset while beats are in flight with acc = 1536
    send(3'd6, 256, 256, 1'b1);
    send(3'd6, 256, 256, 1'b0);
    send(3'd6, 256, 256, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("rst_no_stale", out_valid, 0);
    end
    send(3'd6, 256, 256, 1'b0);
    idle(6);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/svreal_alu_pipe.md
Name: svreal_alu_pipe

Overview:
- Parametrised, pipelined fixed-point ALU over svreal-format operands (signed mantissa, fixed exponent set per port).
- Generalises the combinational svreal operators (add/sub/mul/min/max/negate/compare) into one registered datapath.
- Adds a valid/ready handshake, configurable pipeline depth, a multiply-accumulate mode and optional saturation.
- Sits between stream producers and consumers in svreal datapaths that need timing closure and backpressure.

Parameters:
A_WIDTH, 16, operand a mantissa width (signed)
A_EXPONENT, -8, operand a exponent (value = a_val * 2^A_EXPONENT)
B_WIDTH, 17, operand b mantissa width (signed)
B_EXPONENT, -9, operand b exponent
O_WIDTH, 18, result mantissa width (signed)
O_EXPONENT, -10, result and accumulator exponent
PIPE_DEPTH, 2, register stages from input to output; legal range 1..8

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
op  input  3  0 ADD, 1 SUB, 2 MUL, 3 MIN, 4 MAX, 5 NEG(a), 6 MAC, 7 reserved
acc_clr  input  1  with an accepted beat, zero the accumulator before the MAC
a_val  input  A_WIDTH  operand a mantissa, signed
b_val  input  B_WIDTH  operand b mantissa, signed
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result
out_val  output  O_WIDTH  result mantissa at O_EXPONENT, signed
out_cmp  output  4  {ge, gt, le, lt} of a versus b, exact
out_sat  output  1  result was clipped (always 0 without SVREAL_SAT_EN)

Behaviour:
- Reset (async assert, sync deassert expected): all stage valid bits 0, out_valid 0, out_val 0, out_cmp 0, out_sat 0, accumulator 0. in_ready is 1 when rst_n is high and the pipe is empty.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Whole pipe advances as one unit: advance = !out_valid || out_ready. in_ready = advance (combinational from out_ready).
- Latency is PIPE_DEPTH cycles with no stall. Throughput is 1 beat per cycle. Order is preserved. Bubbles propagate as invalid stages.
- While out_valid && !out_ready, out_val, out_cmp and out_sat hold stable. No beat is dropped or duplicated.
- Alignment:
  - Each operand is rescaled to O_EXPONENT.
  - If exp > O_EXPONENT, shift left, lossless, with internal widening.
  - If exp < O_EXPONENT, arithmetic right shift, truncating toward negative infinity.
  - MUL/MAC: the full product at exponent A_EXPONENT+B_EXPONENT is rescaled once, by the same rule.
- Internal width is wide enough that no intermediate overflows. Only the final narrowing to O_WIDTH can overflow.
- Narrowing without saturation: two's-complement wrap, i.e. keep the low O_WIDTH bits.
- MIN/MAX compare the exact aligned values. Ties return a.
- NEG returns -a. NEG of the most negative value wraps, or saturates under SVREAL_SAT_EN.
- op 7: out_val 0, out_cmp still valid.
- out_cmp is computed on exact values for every op.
- MAC:
  - The accumulator (O_WIDTH at O_EXPONENT) updates at acceptance: acc <= (acc_clr ? 0 : acc) + a*b, narrowed.
  - out_val of that beat equals the new acc.
  - acc_clr on a non-MAC beat zeroes acc. That beat's normal result is unaffected.
  - Back-to-back MACs have no hazard, because the update occurs at acceptance.
- Reset mid-operation: all in-flight beats are discarded and acc is cleared. No out_valid follows reset until a new beat is accepted.

Optional Feature:
- Macro SVREAL_SAT_EN.
- Defined:
  - Narrowing clamps to [-2^(O_WIDTH-1), 2^(O_WIDTH-1)-1].
  - out_sat is 1 for that beat when clamping occurred.
  - The MAC accumulator also saturates.
- Undefined:
  - Narrowing wraps.
  - out_sat is tied 0.
  - No clamp logic is generated.

Test Plan:
- Defaults, a=384 (1.5), b=1152 (2.25), ops 0..5 back-to-back with out_ready=1 -> after 2 cycles out_val = 3840, -768, 3456, 1536, 2304, -1536 on consecutive cycles; out_cmp = {0,0,1,1} for every beat.
- ADD a=25600 (100), b=51200 (100) -> without macro out_val = -57344, out_sat=0; with SVREAL_SAT_EN out_val = 131071, out_sat=1.
- MAC with acc_clr on the first beat, then 3 beats of a=256 (1.0), b=256 (0.5) -> out_val 512, 1024, 1536; a fourth beat with acc_clr=1 -> 512.
- Backpressure: stream 6 ADD beats with out_ready low for cycles 3-5 -> in_ready low on those cycles; all 6 results delivered in order; out_val stable while stalled.
- Bubbles: in_valid alternating 1/0 -> out_valid alternates with 2-cycle latency; with PIPE_DEPTH=1 and then 4, latency is 1 and 4 respectively.
- Assert rst_n low while 2 beats are in flight with acc=1536 -> out_valid 0 immediately (async); after release no stale output; next MAC 256x256 returns 512.
